// File: rtl/mem4x4_writer.sv
// Programs a small RAM from a latched image, reads it back and checks it.
// Reports pass and the first mismatching address on a one-cycle done pulse.
module mem4x4_writer #(
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 4,
  parameter int READ_LAT = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [(2**ADDR_W)*DATA_W-1:0]  load_word,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [ADDR_W-1:0]              err_addr,
  output logic                           we,
  output logic [ADDR_W-1:0]              waddr,
  output logic [DATA_W-1:0]              wdata,
  output logic                           en,
  output logic [ADDR_W-1:0]              addr,
  input  logic [DATA_W-1:0]              data
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CW    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, DRAIN, DONE
  } state_e;

  state_e state_q, state_d;

  logic [DEPTH-1:0][DATA_W-1:0] image_q, image_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CW-1:0]     drn_q, drn_d;
  logic              err_q, err_d;

  logic [READ_LAT-1:0]             pv_q, pv_d;
  logic [READ_LAT-1:0][ADDR_W-1:0] pa_q, pa_d;
  logic [READ_LAT-1:0][DATA_W-1:0] pe_q, pe_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    state_d    = state_q;
    image_d    = image_q;
    idx_d      = idx_q;
    drn_d      = drn_q;
    err_d      = err_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_addr_d = err_addr_q;
    we_d       = we_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    en_d       = en_q;
    addr_d     = addr_q;

    // Each issued read travels with its address and expected word
    pv_d[0] = en_q;
    pa_d[0] = addr_q;
    pe_d[0] = image_q[addr_q];
    for (int i = 1; i < READ_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pa_d[i] = pa_q[i-1];
      pe_d[i] = pe_q[i-1];
    end

    if (pv_q[READ_LAT-1] && !err_q &&
        data != pe_q[READ_LAT-1]) begin
      err_d      = 1'b1;
      err_addr_d = pa_q[READ_LAT-1];
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = WRITE;
          image_d    = load_word;
          err_d      = 1'b0;
          err_addr_d = '0;
          pass_d     = 1'b0;
          idx_d      = '0;
          busy_d     = 1'b1;
          we_d       = 1'b1;
          waddr_d    = '0;
          wdata_d    = load_word[DATA_W-1:0];
        end
      end
      WRITE: begin
        if (idx_q == ADDR_W'(DEPTH-1)) begin
          state_d = READ;
          idx_d   = '0;
          we_d    = 1'b0;
          en_d    = 1'b1;
          addr_d  = '0;
        end else begin
          idx_d   = idx_q + 1'b1;
          waddr_d = idx_q + 1'b1;
          wdata_d = image_q[idx_q + 1'b1];
        end
      end
      READ: begin
        if (idx_q == ADDR_W'(DEPTH-1)) begin
          state_d = DRAIN;
          idx_d   = '0;
          en_d    = 1'b0;
          drn_d   = '0;
        end else begin
          idx_d  = idx_q + 1'b1;
          addr_d = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drn_q == CW'(READ_LAT-1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = ~err_d;
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      image_q    <= '0;
      idx_q      <= '0;
      drn_q      <= '0;
      err_q      <= 1'b0;
      pv_q       <= '0;
      pa_q       <= '0;
      pe_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_addr_q <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      en_q       <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      image_q    <= image_d;
      idx_q      <= idx_d;
      drn_q      <= drn_d;
      err_q      <= err_d;
      pv_q       <= pv_d;
      pa_q       <= pa_d;
      pe_q       <= pe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_addr_q <= err_addr_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_addr = err_addr_q;
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign en       = en_q;
  assign addr     = addr_q;

endmodule

// File: tb/tb_mem4x4_writer.sv
// Bench for mem4x4_writer: RAM model with per-location read corruption,
// directed and random passes checked against a reference outcome.
module tb_mem4x4_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] load_word = '0;
  logic        busy, done, pass, we, en;
  logic [1:0]  err_addr, waddr, addr;
  logic [3:0]  wdata;
  logic [3:0]  data = '0;

  logic [3:0]  mem [4];
  logic [3:0]  corrupt [4];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  mem4x4_writer dut (
    .clk(clk), .reset(reset), .start(start),
    .load_word(load_word), .busy(busy), .done(done),
    .pass(pass), .err_addr(err_addr), .we(we),
    .waddr(waddr), .wdata(wdata), .en(en),
    .addr(addr), .data(data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle-latency RAM; corrupt[] flips bits on readback
  always @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (en) data <= mem[addr] ^ corrupt[addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic run_pass(input logic [15:0] word,
                          input logic [3:0][3:0] mask,
                          input bit extra);
    int t0, rel, nwe, nen, ndone, done_rel, ov;
    logic exp_pass, found, busy1, pass_at, busy_at;
    logic [1:0] exp_err, err_at;
    logic [5:0] wr [8];
    logic [1:0] ra [8];
    nwe = 0; nen = 0; ndone = 0; done_rel = -1; ov = 0;
    busy1 = 0; pass_at = 0; busy_at = 1; err_at = 0;
    found = 0; exp_err = 0;
    for (int i = 0; i < 4; i++) begin
      corrupt[i] = mask[i];
      if (!found && mask[i] != 0) begin
        found = 1;
        exp_err = 2'(i);
      end
    end
    exp_pass = !found;

    @(negedge clk);
    load_word = word;
    start = 1'b1;
    t0 = cyc + 1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      rel = cyc + 1 - t0;
      start = extra && (rel == 3);
      if (rel == 1) busy1 = busy;
      if (we) begin
        if (nwe < 8) wr[nwe] = {waddr, wdata};
        nwe++;
      end
      if (en) begin
        if (nen < 8) ra[nen] = addr;
        nen++;
      end
      if (we && en) ov++;
      if (done) begin
        ndone++;
        done_rel = rel;
        pass_at = pass;
        err_at = err_addr;
        busy_at = busy;
        if (extra) start = 1'b1;
      end
    end
    start = 1'b0;

    chk("busy_after_start", busy1, 1);
    chk("write_count", nwe, 4);
    chk("read_count", nen, 4);
    chk("we_en_overlap", ov, 0);
    chk("done_count", ndone, 1);
    chk("done_cycle", done_rel, 10);
    chk("busy_at_done", busy_at, 0);
    chk("pass", pass_at, exp_pass);
    chk("err_addr", err_at, exp_err);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ai;
      ai = 2'(i);
      if (i < nwe)
        chk("write_seq", wr[i], {ai, word[i*4 +: 4]});
      if (i < nen)
        chk("read_seq", ra[i], ai);
    end
    chk("pass_held", pass, exp_pass);
  endtask

  initial begin
    int nwe, nen, ndone;
    logic [3:0][3:0] m;
    for (int i = 0; i < 4; i++) begin
      mem[i] = '0;
      corrupt[i] = '0;
    end

    // Reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", we, 0);
    chk("rst_en", en, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_addr", err_addr, 0);
    reset = 1'b0;

    run_pass(16'hA5C3, 16'h0000, 0);
    run_pass(16'hA5C3, 16'h0100, 0);
    run_pass(16'hA5C3, 16'h8020, 0);
    run_pass(16'h3C69, 16'h0000, 1);

    // Abort during WRITE
    @(negedge clk);
    load_word = 16'h1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_we_before", we, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_we", we, 0);
    chk("abort_busy", busy, 0);
    reset = 1'b0;
    nwe = 0; nen = 0; ndone = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (we) nwe++;
      if (en) nen++;
      if (done) ndone++;
    end
    chk("abort_no_we", nwe, 0);
    chk("abort_no_en", nen, 0);
    chk("abort_no_done", ndone, 0);
    run_pass(16'h0F0F, 16'h0000, 0);

    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 4; i++)
        m[i] = ($urandom_range(0, 3) == 0) ?
               4'($urandom_range(1, 15)) : 4'h0;
      run_pass(16'($urandom), m, r[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
